// File: rtl/ascon_ti_pkg.sv
// ascon_ti_pkg: shared types, mode encodings and helper functions for the TI Ascon permutation sequencer
package ascon_ti_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CONST,
        S_SBOX,
        S_LIN,
        S_DONE
    } state_e;

    localparam logic [1:0] MODE_P12 = 2'b00;
    localparam logic [1:0] MODE_P8  = 2'b01;
    localparam logic [1:0] MODE_P6  = 2'b10;

    // Mode 11 falls back to the full 12-round permutation
    function automatic logic [3:0] rounds_of(input logic [1:0] m);
        return (m == MODE_P8) ? 4'd8 : (m == MODE_P6) ? 4'd6 : 4'd12;
    endfunction

    function automatic logic [7:0] rc_of(input logic [3:0] i);
        return {4'd15 - i, i};
    endfunction

    function automatic int ns_of(input int slice_w);
        return 64 / slice_w;
    endfunction

    function automatic bit slice_w_legal(input int slice_w);
        return slice_w inside {1, 2, 4, 8, 16, 32, 64};
    endfunction

endpackage

// File: rtl/ascon_ti_rc_gen.sv
// ascon_ti_rc_gen: round-index register and round-constant output
module ascon_ti_rc_gen
    import ascon_ti_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] nr,
    input  logic       inc,
    input  logic       en,
    output logic [3:0] idx,
    output logic [7:0] rc
);

    logic [3:0] idx_q, idx_d;

    // Load starts the index at 12-nr so the last round is always index 11; it never steps past 11
    always_comb begin
        idx_d = load ? 4'd12 - nr : (inc && idx_q != 4'd11) ? idx_q + 4'd1 : idx_q;
    end

    // Round index register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) idx_q <= '0;
        else        idx_q <= idx_d;
    end

    assign idx = idx_q;
    assign rc  = en ? rc_of(idx_q) : 8'h00;

endmodule

// File: rtl/ascon_ti_perm_ctrl.sv
// ascon_ti_perm_ctrl: sequencer for the 3-share TI Ascon permutation datapath (optional ASCON_TI_RND_REFRESH_EN)
module ascon_ti_perm_ctrl
    import ascon_ti_pkg::*;
#(
    parameter  int SLICE_W = 16,
    localparam int NS      = ns_of(SLICE_W),
    localparam int SIW     = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [1:0]     mode,
    output logic           ready,
    output logic           load_en,
    output logic           const_en,
    output logic [7:0]     rc,
    output logic           sbox_en,
    output logic [SIW-1:0] slice_idx,
    output logic           lin_en,
    output logic           done,
    output logic           rnd_ready,
    input  logic           rnd_valid
);

    if (!slice_w_legal(SLICE_W)) begin : g_bad_slice_w
        $error("ascon_ti_perm_ctrl: illegal SLICE_W");
    end

    localparam logic [SIW-1:0] SLICE_LAST = SIW'(NS - 1);

    state_e         state_q, state_d;
    logic [SIW-1:0] slice_q, slice_d;
    logic [3:0]     round_idx;
    logic           adv;

`ifdef ASCON_TI_RND_REFRESH_EN
    assign adv = rnd_valid;
`else
    logic unused_rnd_valid;
    assign adv              = 1'b1;
    assign unused_rnd_valid = rnd_valid;
`endif

    ascon_ti_rc_gen u_rc_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (state_q == S_IDLE && start),
        .nr    (rounds_of(mode)),
        .inc   (state_q == S_LIN),
        .en    (const_en),
        .idx   (round_idx),
        .rc    (rc)
    );

    // State and slice counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            slice_q <= '0;
        end else begin
            state_q <= state_d;
            slice_q <= slice_d;
        end
    end

    // Next state and slice counter; slice clears in CONST so every SBOX entry starts at 0
    always_comb begin
        state_d = state_q;
        slice_d = slice_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_LOAD : S_IDLE;
            S_LOAD:  state_d = S_CONST;
            S_CONST: begin
                state_d = S_SBOX;
                slice_d = '0;
            end
            S_SBOX:  begin
                state_d = (adv && slice_q == SLICE_LAST) ? S_LIN : S_SBOX;
                slice_d = (adv && slice_q != SLICE_LAST) ? slice_q + 1'b1 : slice_q;
            end
            S_LIN:   state_d = (round_idx == 4'd11) ? S_DONE : S_CONST;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore output decode from registered state and counters
    always_comb begin
        ready     = state_q == S_IDLE;
        load_en   = state_q == S_LOAD;
        const_en  = state_q == S_CONST;
        lin_en    = state_q == S_LIN;
        done      = state_q == S_DONE;
`ifdef ASCON_TI_RND_REFRESH_EN
        rnd_ready = state_q == S_SBOX;
        sbox_en   = rnd_ready & rnd_valid;
`else
        rnd_ready = 1'b0;
        sbox_en   = state_q == S_SBOX;
`endif
        slice_idx = (state_q == S_SBOX) ? slice_q : '0;
    end

endmodule
